// File: rtl/shiftreg_pkg.sv
// Shared types and constants for the shift-register sequencer.
// Optional feature macro: PARITY_EN (adds a trailing even-parity bit to every word).
package shiftreg_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } state_t;

endpackage

// File: rtl/shiftreg_if.sv
// Handshake and serial bus between a word producer / serial consumer and shiftreg_ctrl.
// The master side (producer) drives the word, fill bit and abort; the slave side
// (controller) drives ready, the serial stream and status.
interface shiftreg_if import shiftreg_pkg::*; #(parameter int WIDTH = DEF_WIDTH);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] load_val;
  logic             din;
  logic             abort;
  logic             sout;
  logic             sout_valid;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, load_val, din, abort,
    input  start_ready, sout, sout_valid, dout, busy, done
  );

  modport slave (
    input  start_valid, load_val, din, abort,
    output start_ready, sout, sout_valid, dout, busy, done
  );

endinterface

// File: rtl/shiftreg_core.sv
// WIDTH-bit left-shift register datapath: parallel load, or shift left with din into the LSB.
// Load has priority over shift; with neither asserted the register holds.
module shiftreg_core import shiftreg_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] q;

  generate
    if (WIDTH == 1) begin : g_one
      // A one-bit register simply takes din on every shift.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           q <= '0;
        else if (load)     q <= load_val;
        else if (shift_en) q <= din;
      end
    end else begin : g_multi
      // Shift left, filling the vacated LSB from din.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)           q <= '0;
        else if (load)     q <= load_val;
        else if (shift_en) q <= {q[WIDTH-2:0], din};
      end
    end
  endgenerate

  assign dout = q;

endmodule

// File: rtl/shiftreg_ctrl.sv
// Sequencer wrapping shiftreg_core: accepts a word over valid/ready, shifts it out
// MSB-first, then pulses done. Optional macro PARITY_EN appends an even-parity bit
// of the captured word after the last data bit.
module shiftreg_ctrl import shiftreg_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic       clk,
  input logic       rst,
  shiftreg_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             load;
  logic             shift_en;
  logic [WIDTH-1:0] reg_q;

  assign accept = bus.start_valid & bus.start_ready;

  shiftreg_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift_en (shift_en),
    .load_val (bus.load_val),
    .din      (bus.din),
    .dout     (reg_q)
  );

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Bit counter: cleared on acceptance, advanced on every real shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt <= '0;
    else if (accept)   cnt <= '0;
    else if (shift_en) cnt <= cnt + 1'b1;
  end

  // Next-state and datapath controls; abort wins over the final shift.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          state_nx = IDLE;
        end else begin
          shift_en = 1'b1;
          if (cnt == LAST) begin
`ifdef PARITY_EN
            state_nx = PARITY;
`else
            state_nx = DONE;
`endif
          end
        end
      end
      PARITY: begin
`ifdef PARITY_EN
        if (bus.abort) state_nx = IDLE;
        else           state_nx = DONE;
`else
        state_nx = IDLE;
`endif
      end
      DONE: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef PARITY_EN
  logic [WIDTH-1:0] cap_q;

  // Keep a copy of the accepted word so its parity survives the shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cap_q <= '0;
    else if (load) cap_q <= bus.load_val;
  end

  assign bus.sout       = (state == PARITY) ? ^cap_q : reg_q[WIDTH-1];
  assign bus.sout_valid = (state == SHIFT) || (state == PARITY);
`else
  assign bus.sout       = reg_q[WIDTH-1];
  assign bus.sout_valid = (state == SHIFT);
`endif

  assign bus.start_ready = (state == IDLE) & ~rst;
  assign bus.dout        = reg_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);

endmodule
